// File: rtl/vga_if.sv
// Pixel-side bundle between the VGA raster timing generator and the screen logic
// that renders RGB565 for the published coordinate, plus the registered DAC outputs.
interface vga_if;
    logic [15:0] pix_data;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_valid;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic [15:0] rgb;
    logic        frame_start;

    modport master (
        input  pix_data,
        output pix_x, pix_y, pix_valid, hsync, vsync, de, rgb, frame_start
    );

    modport slave (
        output pix_data,
        input  pix_x, pix_y, pix_valid, hsync, vsync, de, rgb, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing (default 640x480@60): free-running h/v counters, combinational
// pixel coordinate for the screen logic, and one aligned output register stage.
module vga_timing_gen #(
    parameter int         H_SYNC   = 96,
    parameter int         H_BACK   = 48,
    parameter int         H_VALID  = 640,
    parameter int         H_FRONT  = 16,
    parameter int         V_SYNC   = 2,
    parameter int         V_BACK   = 33,
    parameter int         V_VALID  = 480,
    parameter int         V_FRONT  = 10,
    parameter logic       SYNC_POL = 1'b0
) (
    input  logic  vga_clk,
    input  logic  sys_rst_n,
    vga_if.master vga
);
    // Both totals must fit the 10-bit counters (<= 1024).
    localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int HA      = H_SYNC + H_BACK;
    localparam int VA      = V_SYNC + V_BACK;

    logic [9:0]  r_cnt_h;
    logic [9:0]  r_cnt_v;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_de;
    logic [15:0] r_rgb;
    logic        r_frame_start;

    logic        w_h_end;
    logic        w_v_end;
    logic        w_pix_valid;

    assign w_h_end = (r_cnt_h == 10'(H_TOTAL - 1));
    assign w_v_end = (r_cnt_v == 10'(V_TOTAL - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            r_cnt_h <= '0;
            r_cnt_v <= '0;
        end else if (w_h_end) begin
            r_cnt_h <= '0;
            r_cnt_v <= w_v_end ? '0 : r_cnt_v + 10'd1;
        end else begin
            r_cnt_h <= r_cnt_h + 10'd1;
        end
    end

    assign w_pix_valid = (r_cnt_h >= 10'(HA)) && (r_cnt_h < 10'(HA + H_VALID)) &&
                         (r_cnt_v >= 10'(VA)) && (r_cnt_v < 10'(VA + V_VALID));

    assign vga.pix_valid = w_pix_valid;
    assign vga.pix_x     = w_pix_valid ? r_cnt_h - 10'(HA) : 10'h3FF;
    assign vga.pix_y     = w_pix_valid ? r_cnt_v - 10'(VA) : 10'h3FF;

    // Single output stage so sync, enable and colour leave on the same edge;
    // the mux keeps pix_data (possibly X) out of rgb during blanking.
    always_ff @(posedge vga_clk) begin
        if (!sys_rst_n) begin
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_de          <= 1'b0;
            r_rgb         <= 16'h0000;
            r_frame_start <= 1'b0;
        end else begin
            r_hsync       <= (r_cnt_h < 10'(H_SYNC)) ? SYNC_POL : ~SYNC_POL;
            r_vsync       <= (r_cnt_v < 10'(V_SYNC)) ? SYNC_POL : ~SYNC_POL;
            r_de          <= w_pix_valid;
            r_rgb         <= w_pix_valid ? vga.pix_data : 16'h0000;
            r_frame_start <= (r_cnt_h == 10'd0) && (r_cnt_v == 10'd0);
        end
    end

    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.de          = r_de;
    assign vga.rgb         = r_rgb;
    assign vga.frame_start = r_frame_start;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size timing for line-level checks, plus a shrunken raster
// instance for whole-frame periodicity within a short run.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic s_rst_n;

    vga_if vif ();
    vga_if sif ();

    vga_timing_gen dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .vga       (vif.master)
    );

    // Small raster: H_TOTAL=16 (HA=6), V_TOTAL=7 (VA=3), frame = 112 cycles.
    vga_timing_gen #(
        .H_SYNC(4), .H_BACK(2), .H_VALID(8), .H_FRONT(2),
        .V_SYNC(2), .V_BACK(1), .V_VALID(3), .V_FRONT(1),
        .SYNC_POL(1'b0)
    ) dut_s (
        .vga_clk   (clk),
        .sys_rst_n (s_rst_n),
        .vga       (sif.master)
    );

    int n_checks = 0;
    int n_errors = 0;
    int k = 0;  // negedges since the last reset release of dut

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic adv(input int target);
        tick(target - k);
        k = target;
    endtask

    initial begin
        int low;
        int fs_cnt, fs_second, vs_low, hs_low, de_hi, rgb_bad, y_max;

        vif.pix_data = 16'h0000;
        sif.pix_data = 16'h5A5A;
        rst_n   = 1'b0;
        s_rst_n = 1'b0;

        // Reset held for 5 edges
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_hsync", vif.hsync, 1'b1);
        chk("rst_vsync", vif.vsync, 1'b1);
        chk("rst_de", vif.de, 1'b0);
        chk("rst_rgb", vif.rgb, 16'h0000);
        chk("rst_frame_start", vif.frame_start, 1'b0);

        rst_n = 1'b1;
        k = 0;
        adv(1);
        chk("fs_first_edge", vif.frame_start, 1'b1);
        chk("hsync_low_start", vif.hsync, 1'b0);
        chk("vsync_low_start", vif.vsync, 1'b0);
        adv(2);
        chk("fs_second_edge", vif.frame_start, 1'b0);

        // hsync pulse width on line 0: samples at k=1..96 must all be low
        low = (vif.hsync === 1'b0) ? 1 : 0;
        for (int i = 3; i <= 96; i++) begin
            adv(i);
            if (vif.hsync === 1'b0) low++;
        end
        chk("hsync_width", low + 1, 96);
        adv(97);
        chk("hsync_rise", vif.hsync, 1'b1);
        adv(800);
        chk("hsync_before_fall", vif.hsync, 1'b1);
        adv(801);
        chk("hsync_period_fall", vif.hsync, 1'b0);

        // First active pixel at (144,35): k = 35*800+144
        adv(28143);
        vif.pix_data = 16'hFFFF;
        chk("pre_active_valid", vif.pix_valid, 1'b0);
        chk("pre_active_x", vif.pix_x, 10'h3FF);
        adv(28144);
        chk("blank_rgb_ignores_data", vif.rgb, 16'h0000);
        chk("first_pix_x", vif.pix_x, 10'd0);
        chk("first_pix_y", vif.pix_y, 10'd0);
        chk("first_pix_valid", vif.pix_valid, 1'b1);
        vif.pix_data = 16'h07E0;
        adv(28145);
        chk("first_de", vif.de, 1'b1);
        chk("first_rgb", vif.rgb, 16'h07E0);
        chk("second_pix_x", vif.pix_x, 10'd1);

        // Right edge of the active line: cnt_h=783 then 784
        adv(28783);
        chk("last_pix_x", vif.pix_x, 10'd639);
        vif.pix_data = 16'h1234;
        adv(28784);
        chk("last_rgb", vif.rgb, 16'h1234);
        chk("after_last_x", vif.pix_x, 10'h3FF);
        chk("after_last_valid", vif.pix_valid, 1'b0);
        vif.pix_data = 16'hxxxx;
        adv(28785);
        chk("front_porch_de", vif.de, 1'b0);
        chk("front_porch_rgb_noX", vif.rgb, 16'h0000);
        vif.pix_data = 16'hFFFF;
        adv(28786);
        chk("front_porch_rgb_ffff", vif.rgb, 16'h0000);

        // Mid-line reset at (400,36): k = 36*800+400
        vif.pix_data = 16'hABCD;
        adv(29200);
        adv(29201);
        chk("pre_reset_de", vif.de, 1'b1);
        chk("pre_reset_rgb", vif.rgb, 16'hABCD);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_de", vif.de, 1'b0);
        chk("midrst_rgb", vif.rgb, 16'h0000);
        chk("midrst_hsync", vif.hsync, 1'b1);
        chk("midrst_vsync", vif.vsync, 1'b1);
        chk("midrst_fs", vif.frame_start, 1'b0);
        chk("midrst_pix_x", vif.pix_x, 10'h3FF);
        rst_n = 1'b1;
        k = 0;
        adv(1);
        chk("restart_fs", vif.frame_start, 1'b1);
        chk("restart_hsync", vif.hsync, 1'b0);
        chk("restart_vsync", vif.vsync, 1'b0);
        adv(97);
        chk("restart_hsync_rise", vif.hsync, 1'b1);
        adv(801);
        chk("restart_hsync_fall", vif.hsync, 1'b0);
        adv(1600);
        chk("restart_vsync_last_low", vif.vsync, 1'b0);
        adv(1601);
        chk("restart_vsync_rise", vif.vsync, 1'b1);

        // Whole-frame behaviour on the small raster over three frames (336 cycles)
        s_rst_n = 1'b1;
        fs_cnt = 0; fs_second = 0; vs_low = 0; hs_low = 0; de_hi = 0; rgb_bad = 0; y_max = 0;
        for (int i = 1; i <= 336; i++) begin
            tick(1);
            if (sif.frame_start === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 2) fs_second = i;
            end
            if (sif.vsync === 1'b0) vs_low++;
            if (sif.hsync === 1'b0) hs_low++;
            if (sif.de === 1'b1) de_hi++;
            if (sif.rgb !== (sif.de === 1'b1 ? 16'h5A5A : 16'h0000)) rgb_bad++;
            if (sif.pix_valid === 1'b1 && int'(sif.pix_y) > y_max) y_max = int'(sif.pix_y);
        end
        chk("frame_start_count", fs_cnt, 3);
        chk("frame_start_period", fs_second, 113);
        chk("vsync_low_cycles", vs_low, 96);
        chk("hsync_low_cycles", hs_low, 84);
        chk("de_cycles", de_hi, 72);
        chk("rgb_vs_de", rgb_bad, 0);
        chk("last_active_row", y_max, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
